// File: rtl/pio_poll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_poll_pkg
// Description : Shared types and helpers for the PIO poll master. Holds the
//               poll FSM state type, the released key level and a counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    PROC = 2'd3
  } poll_state_t;

  // Active-low keys: a released key reads back as 1.
  localparam logic KEY_RELEASED = 1'b1;

  // Width of a counter that runs 0..limit-1. Never returns 0, so a limit of
  // 1 still yields a legal one-bit counter.
  function automatic int cnt_width(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pio_poll_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_poll_if
// Description : Avalon-MM read-only bus between the poll master and a PIO
//               slave.
// Ports       : avm_address (2), avm_read, avm_waitrequest,
//               avm_readdatavalid, avm_readdata (32)
//               master modport drives address/read; slave modport drives
//               waitrequest/readdatavalid/readdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_poll_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdatavalid,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdatavalid,
    output avm_readdata
  );
endinterface
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : pio_debounce_bit
// Description : Debounces one key bit. Each enabled sample that differs from
//               the stable level advances a counter; a matching sample clears
//               it. STABLE_COUNT consecutive differing samples flip the level
//               and emit a one-cycle press (1->0) or release (0->1) pulse.
// Ports       : clk, reset_n (async, active low), en (sample strobe),
//               sample (raw bit), state (debounced level), press, rel (pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce_bit
  import pio_poll_pkg::*;
#(
  parameter int STABLE_COUNT = 4
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  en,
  input  wire  sample,
  output logic state,
  output logic press,
  output logic rel
);

  localparam int            CW       = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [CW-1:0] cnt;
  logic          flip;

  // The sample that would bring the count to STABLE_COUNT flips the level
  // directly, so the counter never has to hold STABLE_COUNT itself.
  assign flip = en && (sample != state) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      state <= KEY_RELEASED;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= flip && (state == KEY_RELEASED);
      rel   <= flip && (state != KEY_RELEASED);
      if (en) begin
        if ((sample == state) || flip) cnt <= '0;
        else                           cnt <= cnt + 1'b1;
        if (flip) state <= ~state;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pio_poll_master.sv
`default_nettype none
// ============================================================================
// Module      : pio_poll_master
// Description : Avalon-MM master that periodically reads a push-button PIO,
//               debounces each key bit and presents stable levels plus
//               one-cycle press/release pulses. Reads that see no
//               readdatavalid within TIMEOUT_CYCLES are abandoned with a
//               timeout_err pulse.
// Ports       : clk, reset_n (async, active low)
//               avm         - pio_poll_if.master read bus
//               key_state   - debounced levels (1 = released)
//               key_press   - pulse on debounced 1->0
//               key_release - pulse on debounced 0->1
//               timeout_err - pulse when a read is abandoned
//               irq, irq_ack - only when PIO_POLL_IRQ_EN is defined
// Config      : PIO_POLL_IRQ_EN adds a sticky irq set by any key press and
//               cleared by irq_ack (a press in the ack cycle wins).
// Revision    : 1.0 - initial release
// ============================================================================
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int         WIDTH          = 2,
  parameter int         POLL_CYCLES    = 50000,
  parameter int         STABLE_COUNT   = 4,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [1:0] POLL_ADDR      = 2'd0
) (
  input  wire              clk,
  input  wire              reset_n,
  pio_poll_if.master       avm,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             timeout_err
`ifdef PIO_POLL_IRQ_EN
  ,
  output logic             irq,
  input  wire              irq_ack
`endif
);

  localparam int            PW        = cnt_width(POLL_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam int            TW        = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  poll_state_t      state, state_nx;
  logic [PW-1:0]    poll_cnt, poll_cnt_nx;
  logic [TW-1:0]    to_cnt, to_cnt_nx;
  logic [WIDTH-1:0] sample, sample_nx;
  logic             timeout_nx;
  logic             proc_en;
  logic             unused_ok;

  assign avm.avm_address = POLL_ADDR;
  assign avm.avm_read    = (state == REQ);
  assign proc_en         = (state == PROC);

  // Only the low WIDTH bits of readdata carry key levels.
  assign unused_ok = &{1'b0, avm.avm_readdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      poll_cnt    <= '0;
      to_cnt      <= '0;
      sample      <= {WIDTH{KEY_RELEASED}};
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      poll_cnt    <= poll_cnt_nx;
      to_cnt      <= to_cnt_nx;
      sample      <= sample_nx;
      timeout_err <= timeout_nx;
    end
  end

  // The timeout counter defaults to zero, so it is already cleared on every
  // entry to WAIT. A readdatavalid outside REQ/WAIT is never looked at.
  always_comb begin
    state_nx    = state;
    poll_cnt_nx = poll_cnt;
    to_cnt_nx   = '0;
    sample_nx   = sample;
    timeout_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (poll_cnt == POLL_LAST) begin
          poll_cnt_nx = '0;
          state_nx    = REQ;
        end else begin
          poll_cnt_nx = poll_cnt + 1'b1;
        end
      end
      REQ: begin
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            sample_nx = avm.avm_readdata[WIDTH-1:0];
            state_nx  = PROC;
          end else begin
            state_nx  = WAIT;
          end
        end
      end
      WAIT: begin
        if (avm.avm_readdatavalid) begin
          sample_nx = avm.avm_readdata[WIDTH-1:0];
          state_nx  = PROC;
        end else if (to_cnt == TO_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          to_cnt_nx  = to_cnt + 1'b1;
        end
      end
      PROC:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .STABLE_COUNT (STABLE_COUNT)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (proc_en),
      .sample  (sample[i]),
      .state   (key_state[i]),
      .press   (key_press[i]),
      .rel     (key_release[i])
    );
  end

`ifdef PIO_POLL_IRQ_EN
  logic irq_q;

  // The live press term lets irq rise in the same cycle as key_press and
  // makes a press coinciding with irq_ack keep the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= (|key_press) | (irq_q & ~irq_ack);
  end

  assign irq = irq_q | (|key_press);
`endif

endmodule
`default_nettype wire

// File: doc/pio_poll_master.md
# pio_poll_master

Avalon-MM master that periodically reads a single-word input PIO slave (push-button style, active-low keys). It debounces each bit over consecutive samples and presents stable key levels plus one-cycle press/release event pulses to fabric logic. It sits beside the soc interconnect as the fabric-side initiator for a PIO responder and removes the need for software polling.

## Interface
- `WIDTH`, default 2: number of key bits taken from readdata[WIDTH-1:0].
- `POLL_CYCLES`, default 50000: clk cycles from the end of one sample to the next read request (1 ms at 50 MHz); minimum 1.
- `STABLE_COUNT`, default 4: consecutive differing samples required to flip a debounced bit; minimum 1.
- `TIMEOUT_CYCLES`, default 16: maximum cycles waiting for readdatavalid before the transaction is abandoned.
- `POLL_ADDR`, default 0: word address driven on avm_address.
- `clk`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `avm_address`  out  2: constant POLL_ADDR.
- `avm_read`  out  1: read request.
- `avm_waitrequest`  in  1: slave stall.
- `avm_readdatavalid`  in  1: read data qualifier.
- `avm_readdata`  in  32: read data; bits above WIDTH ignored.
- `key_state`  out  WIDTH: debounced level (1 = released).
- `key_press`  out  WIDTH: one-cycle pulse on a debounced 1->0 transition.
- `key_release`  out  WIDTH: one-cycle pulse on a debounced 0->1 transition.
- `timeout_err`  out  1: one-cycle pulse when a read times out.

## Operation
- FSM states: IDLE, REQ, WAIT, PROC.
- IDLE: the poll timer counts up. At POLL_CYCLES-1 the timer clears and the FSM moves to REQ.
- REQ: avm_read=1. It is held with a constant address until a cycle with avm_waitrequest=0, then the FSM moves to WAIT. If avm_readdatavalid is also high in that cycle, the FSM captures the data and moves directly to PROC.
- WAIT: the FSM captures avm_readdata on the first avm_readdatavalid and moves to PROC. The timeout counter starts at 0 on entry. If it reaches TIMEOUT_CYCLES-1 with no valid, timeout_err pulses, the sample is discarded, and the FSM returns to IDLE. A late readdatavalid in IDLE is ignored.
- PROC: each bit i is compared against key_state[i].
  - If the sample equals key_state[i], cnt[i] clears.
  - Otherwise cnt[i] increments.
  - When cnt[i] would reach STABLE_COUNT, key_state[i] flips, cnt[i] clears, and the matching press/release bit pulses.
  - The FSM then returns to IDLE.
- Counter widths are $clog2 of their limits. No wrap-around is possible because every counter saturates at its limit and then clears.
- Several bits may change in the same PROC cycle. Their pulses are asserted together.

## Timing
- Reset values:
  - FSM=IDLE, timers=0, cnt=0.
  - key_state = all ones.
  - key_press=0, key_release=0, timeout_err=0, avm_read=0.
- The first avm_read is asserted POLL_CYCLES cycles after reset release.
- With waitrequest low and a fixed slave latency of 1, avm_read is high for exactly 1 cycle. Data is captured one cycle later, and the pulses are registered outputs that assert the cycle after PROC.
- A debounced change takes STABLE_COUNT polls from the first differing sample.
- Reset asserted mid-transaction forces all outputs to reset values immediately. The outstanding read is abandoned.

## Configuration
- `PIO_POLL_IRQ_EN` defined adds two ports:
  - `irq` (out, 1): sticky. Set on any key_press bit. Cleared by `irq_ack` (in, 1) one cycle after ack. A set in the same cycle as an ack wins.
- Undefined: neither port exists and no irq logic is generated.

## Structure
- Shared package `pio_poll_pkg`: FSM state enum (IDLE/REQ/WAIT/PROC), the released level constant `KEY_RELEASED = 1'b1`, and a width helper function.
- One sub-module `pio_debounce_bit`: per-bit counter, stable flop, and press/release pulses, instantiated WIDTH times under a generate loop.

## Test plan
- Reset, then a slave model with latency 1 and readdata=0x3:
  - avm_read first asserts at cycle 50000.
  - key_state stays 2'b11.
  - No pulses.
- readdata goes to 0x2 for 4 consecutive polls:
  - key_press=2'b01 pulses for exactly one cycle after the 4th PROC.
  - key_state=2'b10.
  - Data returning to 0x3 for 4 polls gives key_release=2'b01.
- Bounce pattern 0x2, 0x3, 0x2, 0x2, 0x2, 0x3:
  - No pulse, because the counter clears on each match.
  - key_state stays 2'b11.
- waitrequest held high for 5 cycles:
  - avm_read is held for 6 cycles with a stable address.
  - The sample is processed normally.
- readdatavalid never asserted:
  - timeout_err pulses once 16 cycles into WAIT.
  - The next poll proceeds.
  - A late valid is ignored.
- With PIO_POLL_IRQ_EN, press bit 1:
  - irq rises with key_press.
  - irq_ack clears it next cycle.
  - A simultaneous press and ack keeps irq=1.
